// File: rtl/uart_rx_data_sampler_if.sv
// Bundle of the serial input, control and status signals between the
// oversampling front end and its neighbours in the UART receive path.
// The master drives the line/control inputs; the slave is the sampler.
interface uart_rx_data_sampler_if #(
  parameter int PRESCALE_W = 6,
  parameter int CNT_W      = 4
);
  logic                  rx_in;
  logic                  en_in;
  logic [PRESCALE_W-1:0] prescale_in;
  logic                  sampled_bit_out;
  logic                  sample_valid_out;
  logic [PRESCALE_W-1:0] edge_cnt_out;
  logic [CNT_W-1:0]      bit_cnt_out;
  logic                  bit_done_out;
  logic                  frame_done_out;
  logic                  start_glitch_out;
  logic                  cfg_err_out;

  modport master (
    output rx_in, en_in, prescale_in,
    input  sampled_bit_out, sample_valid_out, edge_cnt_out, bit_cnt_out,
    input  bit_done_out, frame_done_out, start_glitch_out, cfg_err_out
  );

  modport slave (
    input  rx_in, en_in, prescale_in,
    output sampled_bit_out, sample_valid_out, edge_cnt_out, bit_cnt_out,
    output bit_done_out, frame_done_out, start_glitch_out, cfg_err_out
  );
endinterface

// File: rtl/uart_rx_data_sampler.sv
// UART receive oversampling front end. Counts oversampling edges within a
// bit and bits within a frame, takes three samples around the bit centre
// and majority-votes them. Strobes are gated by en_in so nothing leaks out
// while the RX FSM has sampling disabled.
module uart_rx_data_sampler #(
  parameter int PRESCALE_W = 6,
  parameter int FRAME_BITS = 11,
  parameter int CNT_W      = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  uart_rx_data_sampler_if.slave  bus
);

  // Effective oversampling ratio; illegal settings fall back to 8.
  logic                  cfg_legal;
  logic [PRESCALE_W-1:0] p_eff;
  logic [PRESCALE_W-1:0] p_last;
  logic [PRESCALE_W-1:0] p_half;

  // Counters.
  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  edge_last;
  logic                  bit_last;

  // Sampling and strobe state.
  logic                  s0_q, s1_q;
  logic                  sampled_bit_q;
  logic                  valid_q, valid_d;
  logic                  glitch_q, glitch_d;
  logic                  at_s0, at_s1, at_vote;
  logic                  vote;

  // Decode the prescale setting into the ratio actually used.
  always_comb begin
    cfg_legal = (bus.prescale_in == PRESCALE_W'(8))  ||
                (bus.prescale_in == PRESCALE_W'(16)) ||
                (bus.prescale_in == PRESCALE_W'(32));
    p_eff     = cfg_legal ? bus.prescale_in : PRESCALE_W'(8);
    p_last    = p_eff - PRESCALE_W'(1);
    p_half    = p_eff >> 1;
  end

  // Wrap decodes use >= so a ratio change mid-bit cannot strand a counter
  // above its new terminal value.
  always_comb begin
    edge_last = (edge_cnt_q >= p_last);
    bit_last  = (bit_cnt_q >= CNT_W'(FRAME_BITS - 1));
  end

  // Next-state for the edge and bit counters; disabled means cleared.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    if (!bus.en_in) begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (edge_last) begin
      edge_cnt_d = '0;
      bit_cnt_d  = bit_last ? '0 : bit_cnt_q + CNT_W'(1);
    end else begin
      edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
    end
  end

  // Sample points: two early samples, then the vote uses the live line as
  // the third sample so the result is visible one clock later.
  always_comb begin
    at_s0    = bus.en_in && (edge_cnt_q == p_half - PRESCALE_W'(2));
    at_s1    = bus.en_in && (edge_cnt_q == p_half - PRESCALE_W'(1));
    at_vote  = bus.en_in && (edge_cnt_q == p_half);
    vote     = (s0_q & s1_q) | (s0_q & bus.rx_in) | (s1_q & bus.rx_in);
    valid_d  = at_vote;
    glitch_d = at_vote && (bit_cnt_q == '0) && vote;
  end

  // Edge and bit counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  // Capture the early samples and the voted bit; the voted bit holds while
  // disabled so downstream logic keeps seeing the last received value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0_q          <= 1'b0;
      s1_q          <= 1'b0;
      sampled_bit_q <= 1'b1;
    end else begin
      if (at_s0)   s0_q          <= bus.rx_in;
      if (at_s1)   s1_q          <= bus.rx_in;
      if (at_vote) sampled_bit_q <= vote;
    end
  end

  // One-cycle valid and false-start strobes following the vote edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      glitch_q <= glitch_d;
    end
  end

  // Output drive; all strobes are qualified by the enable so that a
  // falling en_in suppresses anything pending.
  always_comb begin
    bus.sampled_bit_out  = sampled_bit_q;
    bus.sample_valid_out = valid_q & bus.en_in;
    bus.start_glitch_out = glitch_q & bus.en_in;
    bus.edge_cnt_out     = edge_cnt_q;
    bus.bit_cnt_out      = bit_cnt_q;
    bus.bit_done_out     = bus.en_in & edge_last;
    bus.frame_done_out   = bus.en_in & edge_last & bit_last;
    bus.cfg_err_out      = ~cfg_legal;
  end

endmodule

// File: tb/tb_uart_rx_data_sampler.sv
// Self-checking bench for the UART RX oversampling front end. A cycle model
// derives counters from the number of consecutive enabled clocks, and the
// voted bit from a short history of the line.
module tb_uart_rx_data_sampler;
  localparam int PW = 6;
  localparam int FB = 11;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_data_sampler_if #(.PRESCALE_W(PW), .CNT_W(CW)) bus ();

  uart_rx_data_sampler #(.PRESCALE_W(PW), .FRAME_BITS(FB), .CNT_W(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model state.
  int k = 0;          // consecutive enabled clocks already completed
  bit hist[$];        // line values during recent enabled clocks
  bit exp_sb = 1'b1;  // expected voted bit

  // Observations from the latest step.
  int obs_edge, obs_bit;
  bit obs_valid, obs_sb, obs_bd, obs_fd, obs_gl, obs_err;

  typedef struct {
    int pre;
    int exp_err;
    int exp_p;
  } cfg_vec_t;
  cfg_vec_t tbl[9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int eff_p(input int pre);
    if (pre == 8 || pre == 16 || pre == 32) return pre;
    return 8;
  endfunction

  function automatic bit maj3(input bit a, input bit b, input bit c);
    return (int'(a) + int'(b) + int'(c)) >= 2;
  endfunction

  // One clock: drive, check at negedge, then advance the model.
  task automatic step(input bit rx, input bit en);
    int p, e, b;
    bit x_valid, x_bd, x_fd, x_gl;
    bus.rx_in = rx;
    bus.en_in = en;
    @(negedge clk);
    p = eff_p(int'(bus.prescale_in));
    e = k % p;
    b = (k / p) % FB;
    x_valid = en && (e == p / 2 + 1);
    x_bd    = en && (e == p - 1);
    x_fd    = x_bd && (b == FB - 1);
    x_gl    = x_valid && (b == 0) && exp_sb;
    obs_edge  = int'(bus.edge_cnt_out);
    obs_bit   = int'(bus.bit_cnt_out);
    obs_valid = bus.sample_valid_out;
    obs_sb    = bus.sampled_bit_out;
    obs_bd    = bus.bit_done_out;
    obs_fd    = bus.frame_done_out;
    obs_gl    = bus.start_glitch_out;
    obs_err   = bus.cfg_err_out;
    chk("edge_cnt", obs_edge, e);
    chk("bit_cnt", obs_bit, b);
    chk("sample_valid", int'(obs_valid), int'(x_valid));
    chk("sampled_bit", int'(obs_sb), int'(exp_sb));
    chk("bit_done", int'(obs_bd), int'(x_bd));
    chk("frame_done", int'(obs_fd), int'(x_fd));
    chk("start_glitch", int'(obs_gl), int'(x_gl));
    chk("cfg_err", int'(obs_err), (p == int'(bus.prescale_in)) ? 0 : 1);
    if (obs_valid)
      $display("sample: P=%0d bit=%0d edge=%0d value=%0b glitch=%0b", p, obs_bit, obs_edge, obs_sb, obs_gl);
    @(posedge clk);
    #1;
    if (en) begin
      if (e == p / 2) exp_sb = maj3(hist[hist.size()-2], hist[hist.size()-1], rx);
      hist.push_back(rx);
      if (hist.size() > 4) void'(hist.pop_front());
      k++;
    end else begin
      k = 0;
      hist.delete();
    end
  endtask

  // Change the ratio only after the counters have settled to zero.
  task automatic set_prescale(input int pre);
    step(1'b1, 1'b0);
    bus.prescale_in = PW'(pre);
    step(1'b1, 1'b0);
  endtask

  initial begin
    logic [10:0] fr;
    int vidx, fd_at, bd_at, val_at, nvalid, pre_sel;
    int pres[6];
    bit got[FB];

    pres[0] = 8; pres[1] = 16; pres[2] = 32; pres[3] = 12; pres[4] = 0; pres[5] = 40;
    tbl[0] = '{8, 0, 8};   tbl[1] = '{16, 0, 16}; tbl[2] = '{32, 0, 32};
    tbl[3] = '{12, 1, 8};  tbl[4] = '{0, 1, 8};   tbl[5] = '{7, 1, 8};
    tbl[6] = '{24, 1, 8};  tbl[7] = '{33, 1, 8};  tbl[8] = '{63, 1, 8};

    bus.rx_in = 1'b1;
    bus.en_in = 1'b0;
    bus.prescale_in = PW'(8);

    // Reset state.
    @(negedge clk);
    chk("reset sampled_bit", int'(bus.sampled_bit_out), 1);
    chk("reset valid", int'(bus.sample_valid_out), 0);
    chk("reset edge_cnt", int'(bus.edge_cnt_out), 0);
    chk("reset bit_cnt", int'(bus.bit_cnt_out), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Table: ratio decode, first valid edge and first wrap per setting.
    for (int i = 0; i < 9; i++) begin
      set_prescale(tbl[i].pre);
      chk("tbl cfg_err", int'(obs_err), tbl[i].exp_err);
      bd_at = -1;
      val_at = -1;
      for (int c = 0; c < 64 && bd_at < 0; c++) begin
        step(1'b1, 1'b1);
        if (obs_valid && val_at < 0) val_at = c;
        if (obs_bd) bd_at = c;
      end
      chk("tbl first valid edge", val_at, tbl[i].exp_p / 2 + 1);
      chk("tbl first wrap edge", bd_at, tbl[i].exp_p - 1);
      step(1'b1, 1'b0);
    end

    // P=8 frame: start, 0xA5 LSB first, even parity, stop.
    set_prescale(8);
    fr = {1'b1, ^8'hA5, 8'hA5, 1'b0};
    vidx = 0;
    fd_at = -1;
    for (int c = 0; c < 88; c++) begin
      step(fr[c / 8], 1'b1);
      if (obs_valid) begin
        chk("frame valid edge", obs_edge, 5);
        if (vidx < FB) got[vidx] = obs_sb;
        vidx++;
      end
      if (obs_fd) fd_at = c;
    end
    chk("frame valid count", vidx, FB);
    for (int i = 0; i < FB; i++) chk("frame bit value", int'(got[i]), int'(fr[i]));
    chk("frame_done clock", fd_at, 87);
    step(1'b1, 1'b0);

    // P=16: line dips low only at edge 7 of a '1' bit.
    set_prescale(16);
    for (int c = 0; c < 16; c++) step(1'b0, 1'b1);
    val_at = -1;
    bd_at = -1;
    for (int c = 0; c < 16; c++) begin
      step((c == 7) ? 1'b0 : 1'b1, 1'b1);
      if (obs_valid) begin
        val_at = obs_edge;
        chk("glitch16 vote", int'(obs_sb), 1);
      end
      if (obs_bd) bd_at = obs_edge;
    end
    chk("glitch16 valid edge", val_at, 9);
    chk("glitch16 bit_done edge", bd_at, 15);
    step(1'b1, 1'b0);

    // P=32: start bit low only for edges 0..10 -> false start.
    set_prescale(32);
    val_at = -1;
    for (int c = 0; c < 32; c++) begin
      step((c <= 10) ? 1'b0 : 1'b1, 1'b1);
      if (obs_valid) begin
        val_at = obs_edge;
        chk("false start glitch", int'(obs_gl), 1);
        chk("false start bit", obs_bit, 0);
      end
    end
    chk("false start valid edge", val_at, 17);
    step(1'b1, 1'b0);

    // P=8: enable dropped at bit 4 edge 3 for 5 clocks.
    set_prescale(8);
    for (int c = 0; c < 35; c++) step(1'b0, 1'b1);
    nvalid = 0;
    for (int j = 0; j < 5; j++) begin
      step(1'b0, 1'b0);
      if (obs_valid) nvalid++;
      if (j == 0) begin
        chk("abort edge before clear", obs_edge, 3);
        chk("abort bit before clear", obs_bit, 4);
      end else begin
        chk("abort edge cleared", obs_edge, 0);
        chk("abort bit cleared", obs_bit, 0);
      end
    end
    chk("abort valid count", nvalid, 0);
    step(1'b0, 1'b1);
    chk("restart edge", obs_edge, 0);
    chk("restart bit", obs_bit, 0);
    step(1'b1, 1'b0);

    // P=16: asynchronous reset at bit 6 edge 4, then a full frame.
    set_prescale(16);
    for (int c = 0; c < 100; c++) step(1'b0, 1'b1);
    bus.en_in = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("async reset sampled_bit", int'(bus.sampled_bit_out), 1);
    chk("async reset edge_cnt", int'(bus.edge_cnt_out), 0);
    chk("async reset bit_cnt", int'(bus.bit_cnt_out), 0);
    chk("async reset valid", int'(bus.sample_valid_out), 0);
    chk("async reset glitch", int'(bus.start_glitch_out), 0);
    chk("async reset frame_done", int'(bus.frame_done_out), 0);
    k = 0;
    hist.delete();
    exp_sb = 1'b1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    fd_at = -1;
    for (int c = 0; c < 400 && fd_at < 0; c++) begin
      step(1'b0, 1'b1);
      if (obs_fd) fd_at = c;
    end
    chk("post-reset frame_done clock", fd_at, 175);
    step(1'b1, 1'b0);

    // Randomised segments: random ratio, per-bit line levels with
    // occasional single-clock glitches, and occasional enable drops.
    for (int s = 0; s < 24; s++) begin
      pre_sel = pres[$urandom_range(0, 5)];
      set_prescale(pre_sel);
      begin
        int p, len;
        bit lvl;
        p = eff_p(pre_sel);
        len = $urandom_range(p * 2, p * (FB + 2));
        lvl = 1'b0;
        for (int c = 0; c < len; c++) begin
          if (c % p == 0) lvl = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 99) < 3) step(lvl, 1'b0);
          else step(($urandom_range(0, 99) < 10) ? ~lvl : lvl, 1'b1);
        end
      end
      step(1'b1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
